instr_fetch_buffer: RTL and testbench
=====================================

// Module: instr_fetch_buffer
// PURPOSE
//  Instruction fetch stage directly upstream of the control unit.
//  - Owns the PC, issues single-outstanding reads to instruction memory, and buffers fetched words in a small FIFO.
//  - Presents {pc, instr} to decode through a valid/ready handshake.
//  - id_opcode (instr[31:26]) drives the control unit's oper_in.
//  - redirect loads a new PC and flushes all in-flight and buffered instructions.
// PARAMETERS
//  ADDR_W    32    PC / memory address width
//  DATA_W    32    instruction width (>= 32; opcode = bits [31:26])
//  DEPTH     2     FIFO entries (power of 2, >= 2)
//  RESET_PC  0     PC value loaded on reset
//  PC_STEP   4     PC increment per accepted request
// PORTS
//  clk          in   1                clock, all state on rising edge
//  rst_n        in   1                synchronous reset, active low
//  imem_req     out  1                fetch request valid
//  imem_addr    out  ADDR_W           fetch address (= pc register)
//  imem_gnt     in   1                memory accepts request (req & gnt = handshake)
//  imem_rvalid  in   1                response valid, 1-cycle pulse, >=1 cycle after grant
//  imem_rdata   in   DATA_W           response instruction word
//  redirect     in   1                load redirect_pc, flush pipeline
//  redirect_pc  in   ADDR_W           new fetch address
//  id_valid     out  1                FIFO head valid for decode
//  id_ready     in   1                decode consumes head
//  id_instr     out  DATA_W           head instruction
//  id_pc        out  ADDR_W           address of head instruction
//  id_opcode    out  6                id_instr[31:26], to control unit oper_in
//  fifo_count   out  clog2(DEPTH)+1   buffered entries
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge)
//   - pc=RESET_PC; state=REQ; count, rd/wr pointers = 0.
//   - imem_req and id_valid are gated combinationally by rst_n: both are 0 whenever rst_n=0.
//  FSM states
//   - REQ:  imem_req = (count < DEPTH). On req & gnt: req_pc <= pc, pc <= pc + PC_STEP (wraps modulo 2^ADDR_W), go to WAIT.
//   - WAIT: imem_req = 0. On rvalid: push {req_pc, rdata}, go to REQ.
//   - DROP: imem_req = 0. On rvalid: discard the data, go to REQ.
//   - imem_rvalid in state REQ is ignored (stale response after reset).
//  Redirect (highest priority)
//   - pc <= redirect_pc; count <= 0; pointers <= 0; id_valid forced 0 in the redirect cycle.
//   - In WAIT without rvalid that cycle -> DROP. In WAIT with rvalid that cycle -> discard the data, go to REQ.
//   - In REQ with req & gnt that cycle -> DROP; the granted address is stale and pc does not advance.
//   - In DROP -> stays in DROP.
//  FIFO
//   - id_valid = (count != 0). Pop on id_valid & id_ready.
//   - Push and pop in the same cycle: count unchanged.
//   - Only one request is ever outstanding, and it is issued only when count < DEPTH, so a push never overflows.
//   - Order is strictly preserved.
//  Latency
//   - grant at cycle t, rvalid at t+k: the entry is visible on id_* at t+k+1.
//   - With gnt tied 1 and k=1, sustained throughput is 1 instruction per 2 cycles.
// TESTING
//  1. rst_n=0 for 2 cycles -> imem_req=0, id_valid=0, fifo_count=0; release -> imem_req=1, imem_addr=0x0.
//  2. gnt=1, rvalid 1 cycle after gnt, id_ready=1, mem[0x0]=0x8C220004 -> id_pc=0x0, id_opcode=6'b100011; next fetches issue at 0x4, 0x8 in order.
//  3. id_ready=0 -> after 2 responses fifo_count=2, imem_req=0; then id_ready=1 -> id_pc 0x0, 0x4 drained in order, imem_req reasserts at 0x8.
//  4. redirect=1, redirect_pc=0x40 while in WAIT -> late rvalid data never reaches id_*, fifo_count=0, next imem_addr=0x40.
//  5. redirect in the same cycle as req & gnt at 0x10 -> that response is dropped, next request at 0x40, first id_pc=0x40.
//  6. rst_n=0 while in WAIT, rvalid arrives after release -> response ignored, fetch restarts at RESET_PC, id_valid stays 0 until new data.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads and
// buffers returned words in a small FIFO presented to decode via valid/ready.
module instr_fetch_buffer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [DATA_W-1:0]          id_instr,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [5:0]                 id_opcode,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(PC_STEP);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic handshake;
    logic push;
    logic pop;

    assign imem_req   = rst_n & (state_q == ST_REQ) & (count_q < DEPTH_C);
    assign imem_addr  = pc_q;
    assign id_valid   = rst_n & ~redirect & (count_q != '0);
    assign id_instr   = instr_mem_q[rd_ptr_q];
    assign id_pc      = pc_mem_q[rd_ptr_q];
    assign id_opcode  = id_instr[31:26];
    assign fifo_count = count_q;

    assign handshake = imem_req & imem_gnt;
    assign pop       = id_valid & id_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (handshake) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + STEP_C;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Redirect flushes everything; any response still owed by memory must be
        // absorbed in DROP. A response arriving in DROP this cycle is the owed one.
        if (redirect) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            push     = 1'b0;
            case (state_q)
                ST_REQ:  state_d = handshake   ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rvalid ? ST_REQ  : ST_DROP;
                ST_DROP: state_d = imem_rvalid ? ST_REQ  : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with an in-bench instruction memory
// whose response latency is set per step.
module tb_instr_fetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [1:0]  fifo_count;

    int vectors;
    int miscompares;
    int lat;
    int lat_cnt;
    logic [31:0] pend_addr;

    instr_fetch_buffer #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_opcode(id_opcode), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8C220004 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshake before the edge, then model memory after it.
    task automatic tick();
        logic hs;
        logic [31:0] a;
        hs = imem_req & imem_gnt;
        a  = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (hs) begin
            pend_addr = a;
            lat_cnt   = lat;
        end
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; lat = 1; lat_cnt = 0; pend_addr = '0;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // 1: reset
        tick(); tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_count", {30'b0, fifo_count}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        // 2: basic fetch
        imem_gnt = 1'b1; id_ready = 1'b1;
        tick();
        chk("wait_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("f0_valid", {31'b0, id_valid}, 32'd1);
        chk("f0_pc", id_pc, 32'h0);
        chk("f0_instr", id_instr, 32'h8C220004);
        chk("f0_opc", {26'b0, id_opcode}, 32'h23);
        chk("f1_addr", imem_addr, 32'h4);
        tick();
        chk("f1_valid", {31'b0, id_valid}, 32'd0);
        tick();
        chk("f1_pc", id_pc, 32'h4);
        chk("f2_addr", imem_addr, 32'h8);

        // 3: backpressure from a fresh reset
        rst_n = 1'b0; id_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        tick(); tick(); tick(); tick();
        chk("bp_count", {30'b0, fifo_count}, 32'd2);
        chk("bp_req", {31'b0, imem_req}, 32'd0);
        chk("bp_head", id_pc, 32'h0);
        tick();
        chk("bp_hold", {30'b0, fifo_count}, 32'd2);
        id_ready = 1'b1;
        #1;
        chk("dr0_pc", id_pc, 32'h0);
        tick();
        chk("dr1_pc", id_pc, 32'h4);
        chk("dr_req", {31'b0, imem_req}, 32'd1);
        chk("dr_addr", imem_addr, 32'h8);

        // 4: redirect while waiting, late response
        lat = 2;
        tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("rd_valid0", {31'b0, id_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        chk("drop_req", {31'b0, imem_req}, 32'd0);
        lat = 1;
        tick();
        chk("rd_valid1", {31'b0, id_valid}, 32'd0);
        chk("rd_count", {30'b0, fifo_count}, 32'd0);
        chk("rd_req", {31'b0, imem_req}, 32'd1);
        chk("rd_addr", imem_addr, 32'h40);
        tick(); tick();
        chk("rd_pc", id_pc, 32'h40);
        chk("rd_instr", id_instr, mem_word(32'h40));

        // 5: redirect coincident with grant at 0x10
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect = 1'b0; imem_gnt = 1'b1;
        #1;
        chk("g_addr10", imem_addr, 32'h10);
        chk("g_valid0", {31'b0, id_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("g_drop_req", {31'b0, imem_req}, 32'd0);
        chk("g_pc", imem_addr, 32'h40);
        tick();
        chk("g_valid1", {31'b0, id_valid}, 32'd0);
        chk("g_req", {31'b0, imem_req}, 32'd1);
        chk("g_addr40", imem_addr, 32'h40);
        tick(); tick();
        chk("g_first_pc", id_pc, 32'h40);
        chk("g_first_instr", id_instr, mem_word(32'h40));

        // 6: reset during WAIT, response arrives after release
        lat = 3;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rw_req", {31'b0, imem_req}, 32'd0);
        chk("rw_valid", {31'b0, id_valid}, 32'd0);
        imem_gnt = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rw_rel_req", {31'b0, imem_req}, 32'd1);
        chk("rw_rel_addr", imem_addr, 32'h0);
        tick();
        chk("rw_stale", {31'b0, imem_rvalid}, 32'd1);
        tick();
        chk("rw_ign_valid", {31'b0, id_valid}, 32'd0);
        chk("rw_ign_count", {30'b0, fifo_count}, 32'd0);
        imem_gnt = 1'b1; lat = 1;
        tick(); tick();
        chk("rw_new_pc", id_pc, 32'h0);
        chk("rw_new_instr", id_instr, mem_word(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
